// File: rtl/fft_piso.sv
// fft_piso: captures a 16-word FFT frame in parallel and streams it out one
// word per accepted beat. The output order is natural or 4-bit bit-reversed.
// The buffer is never shifted: the slot counter selects which word is shown,
// so a stall simply freezes the counter.
module fft_piso #(
  parameter int DW     = 32,
  parameter int BITREV = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [16*DW-1:0]   para_in,
  input  logic               para_valid,
  output logic               para_ready,
  output logic [DW-1:0]      ser_d,
  output logic               ser_valid,
  input  logic               ser_ready,
  output logic [3:0]         ser_idx,
  output logic               ser_last
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic [DW-1:0] r_buf [16];

  logic          w_para_ready;
  logic          w_accept;
  logic          w_xfer;
  logic          w_cnt_last;
  logic [3:0]    w_idx;

  // Reverse the bit order of a 4-bit slot number.
  function automatic logic [3:0] bit_rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  assign w_cnt_last = (r_cnt == 4'd15);
  assign w_idx      = (BITREV != 0) ? bit_rev4(r_cnt) : r_cnt;
  assign w_accept   = para_valid && w_para_ready;
  assign w_xfer     = ser_valid && ser_ready;
  assign para_ready = w_para_ready;

  // State and slot counter register; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic: a new frame restarts at slot 0, even on the last beat.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = 4'd0;
        end
      end
      S_SEND: begin
        if (w_accept) begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = 4'd0;
        end else if (w_xfer) begin
          if (w_cnt_last) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
          end else begin
            w_state_nxt = S_SEND;
            w_cnt_nxt   = r_cnt + 4'd1;
          end
        end else begin
          w_state_nxt = S_SEND;
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Output decode: IDLE drives zeros; SEND shows the selected buffer word.
  always_comb begin
    w_para_ready = 1'b0;
    ser_valid    = 1'b0;
    ser_idx      = 4'd0;
    ser_d        = '0;
    ser_last     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_para_ready = 1'b1;
      end
      S_SEND: begin
        w_para_ready = w_cnt_last && ser_ready;
        ser_valid    = 1'b1;
        ser_idx      = w_idx;
        ser_d        = r_buf[w_idx];
        ser_last     = w_cnt_last;
      end
      default: begin
        w_para_ready = 1'b0;
      end
    endcase
  end

  // Frame buffer: cleared on reset, loaded only when a frame is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) begin
        r_buf[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < 16; k++) begin
        r_buf[k] <= para_in[k*DW +: DW];
      end
    end else begin
      for (int k = 0; k < 16; k++) begin
        r_buf[k] <= r_buf[k];
      end
    end
  end

endmodule
